// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and pixel types, common to the timing
// generator and the GPU pixel-fetch stage.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned ROW_W = 9;
    localparam int unsigned COL_W = 10;
    localparam int unsigned R_W   = 4;
    localparam int unsigned G_W   = 4;
    localparam int unsigned B_W   = 4;
    localparam int unsigned RGB_W = R_W + G_W + B_W;

    // Out-of-range scan markers so the GPU bounds check fails during blank.
    localparam logic [ROW_W-1:0] ROW_BLANK = 9'd480;
    localparam logic [COL_W-1:0] COL_BLANK = 10'd640;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb444_t;

    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_pix_tick_gen.sv
// Pixel-rate clock enable: one-clk tick every CLK_DIV system clocks, on the
// last phase of each pixel.
module pix_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator and RGB444 output stage; scan position feeds the GPU
// fetch stage, whose pixel comes back at the last phase of the same pixel.
module vga_timing #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] vga_data,
    output logic [8:0]  row,
    output logic [9:0]  col,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        video_on,
    output logic        frame_start
);

    import vga_pkg::*;

    localparam logic [CNT_W-1:0] HA      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HT_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VA      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VT_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic tick;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    rgb444_t          rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             video_on_q, video_on_d;
    logic             frame_start_q, frame_start_d;
    logic             first_q;
    logic             h_wrap;
    logic             v_wrap;

    always_comb begin
        h_wrap  = (h_cnt_q == HT_LAST);
        v_wrap  = (v_cnt_q == VT_LAST);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
            end
        end
    end

    // Scan position tracks the pixel about to start; outputs describe the one just ending.
    always_comb begin
        col_d = (h_cnt_d < HA) ? h_cnt_d : COL_BLANK;
        row_d = (v_cnt_d < VA) ? v_cnt_d[ROW_W-1:0] : ROW_BLANK;

        video_on_d = (h_cnt_q < HA) && (v_cnt_q < VA);
        rgb_d      = video_on_d ? rgb444_t'(vga_data) : '0;
        hs_d       = !in_window(h_cnt_q, HS_LO, HS_HI);
        vs_d       = !in_window(v_cnt_q, VS_LO, VS_HI);

        frame_start_d = tick && ((h_wrap && v_wrap) || first_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            if (tick) begin
                col_q      <= col_d;
                row_q      <= row_d;
                rgb_q      <= rgb_d;
                hs_q       <= hs_d;
                vs_q       <= vs_d;
                video_on_q <= video_on_d;
                first_q    <= 1'b0;
            end
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign r           = rgb_q.r;
    assign g           = rgb_q.g;
    assign b           = rgb_q.b;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full-width lines, shortened vertical timing
// (4 visible lines, 8 per frame) so whole frames fit in a short run.
module tb_vga_timing;

    localparam int PIX_LINE  = 800;
    localparam int LINES     = 8;
    localparam int LINE_CLK  = PIX_LINE * 4;
    localparam int FRAME_PIX = PIX_LINE * LINES;
    localparam int FRAME_CLK = FRAME_PIX * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] vga_data;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [3:0]  r, g, b;
    logic        hs, vs, video_on, frame_start;

    always #5 clk = ~clk;

    vga_timing #(
        .CLK_DIV  (4),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_data    (vga_data),
        .row         (row),
        .col         (col),
        .r           (r),
        .g           (g),
        .b           (b),
        .hs          (hs),
        .vs          (vs),
        .video_on    (video_on),
        .frame_start (frame_start)
    );

    // GPU stand-in: fixed 3-clk latency from row/col to vga_data.
    logic [11:0] p1, p2, p3;
    logic        gpu_const = 1'b0;
    always @(posedge clk) begin
        p1 <= {col[3:0], row[3:0], 4'hA};
        p2 <= p1;
        p3 <= p2;
    end
    assign vga_data = gpu_const ? 12'hFFF : p3;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    int e_col, e_row, e_hs, e_vs, e_von, e_rgb, e_fs;
    int hs_low, col_blank, vs_low, row_blank, blank_leak, fff_clks;
    int hs_fall[2], n_hs_fall;
    int fs_k[4], n_fs;
    logic [9:0]  col_k3, col_k4, col_k8, col_5_2;
    logic [8:0]  row_5_2;
    logic [11:0] rgb_5_2;
    logic        von_5_2, fs_k4;

    // k = clock edges since reset release; expectations are closed-form in k.
    task automatic run_span(input int n_clk, input int const_from);
        int p, h, v, q, hq, vq;
        logic [9:0]  x_col;
        logic [8:0]  x_row;
        logic [11:0] x_rgb;
        logic        x_hs, x_vs, x_von, x_fs, prev_hs;
        e_col = 0; e_row = 0; e_hs = 0; e_vs = 0; e_von = 0; e_rgb = 0; e_fs = 0;
        hs_low = 0; col_blank = 0; vs_low = 0; row_blank = 0; blank_leak = 0; fff_clks = 0;
        n_hs_fall = 0; n_fs = 0; prev_hs = 1'b1;
        for (int k = 1; k <= n_clk; k++) begin
            @(posedge clk);
            @(negedge clk);
            p = k / 4;
            h = p % PIX_LINE;
            v = (p / PIX_LINE) % LINES;
            x_col = (h < 640) ? 10'(h) : 10'd640;
            x_row = (v < 4) ? 9'(v) : 9'd480;
            if (p == 0) begin
                x_von = 1'b0; x_hs = 1'b1; x_vs = 1'b1; x_rgb = 12'h000;
            end else begin
                q  = p - 1;
                hq = q % PIX_LINE;
                vq = (q / PIX_LINE) % LINES;
                x_von = (hq < 640) && (vq < 4);
                x_hs  = !(hq >= 656 && hq <= 751);
                x_vs  = !(vq >= 5 && vq <= 6);
                if (!x_von)                   x_rgb = 12'h000;
                else if (k - k % 4 > const_from) x_rgb = 12'hFFF;
                else                          x_rgb = {4'(hq), 4'(vq), 4'hA};
            end
            x_fs = (k == 4) || (k % 4 == 0 && p % FRAME_PIX == 0);

            if (col !== x_col)              e_col++;
            if (row !== x_row)              e_row++;
            if (hs !== x_hs)                e_hs++;
            if (vs !== x_vs)                e_vs++;
            if (video_on !== x_von)         e_von++;
            if ({r, g, b} !== x_rgb)        e_rgb++;
            if (frame_start !== x_fs)       e_fs++;

            if (k < LINE_CLK && hs == 1'b0)      hs_low++;
            if (k < LINE_CLK && col == 10'd640)  col_blank++;
            if (k < FRAME_CLK && vs == 1'b0)     vs_low++;
            if (k < FRAME_CLK && row == 9'd480)  row_blank++;
            if (k >= FRAME_CLK && k < 2 * FRAME_CLK) begin
                if (!video_on && {r, g, b} != 12'h000) blank_leak++;
                if ({r, g, b} == 12'hFFF)              fff_clks++;
            end
            if (prev_hs && !hs && n_hs_fall < 2) begin
                hs_fall[n_hs_fall] = k;
                n_hs_fall++;
            end
            prev_hs = hs;
            if (frame_start && n_fs < 4) begin
                fs_k[n_fs] = k;
                n_fs++;
            end
            if (k == 3) col_k3 = col;
            if (k == 4) begin col_k4 = col; fs_k4 = frame_start; end
            if (k == 8) col_k8 = col;
            if (k == 6420) begin col_5_2 = col; row_5_2 = row; end
            if (k == 6424) begin rgb_5_2 = {r, g, b}; von_5_2 = video_on; end
            if (k == const_from) gpu_const = 1'b1;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_row"}, 32'(row), 32'd0);
        chk({tag, "_col"}, 32'(col), 32'd0);
        chk({tag, "_rgb"}, 32'({r, g, b}), 32'h000);
        chk({tag, "_hs"}, 32'(hs), 32'd1);
        chk({tag, "_vs"}, 32'(vs), 32'd1);
        chk({tag, "_von"}, 32'(video_on), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("por");
        rst = 1'b0;

        run_span(62000, 20000);
        chk("col_trace", 32'(e_col), 32'd0);
        chk("row_trace", 32'(e_row), 32'd0);
        chk("hs_trace", 32'(e_hs), 32'd0);
        chk("vs_trace", 32'(e_vs), 32'd0);
        chk("von_trace", 32'(e_von), 32'd0);
        chk("rgb_trace", 32'(e_rgb), 32'd0);
        chk("fs_trace", 32'(e_fs), 32'd0);
        chk("col_before_tick", 32'(col_k3), 32'd0);
        chk("col_first_tick", 32'(col_k4), 32'd1);
        chk("col_second_tick", 32'(col_k8), 32'd2);
        chk("fs_first_tick", 32'(fs_k4), 32'd1);
        chk("hs_low_clks", 32'(hs_low), 32'd384);
        chk("col_blank_clks", 32'(col_blank), 32'd640);
        chk("hs_fall_count", 32'(n_hs_fall), 32'd2);
        chk("hs_fall_first", 32'(hs_fall[0]), 32'd2628);
        chk("hs_fall_period", 32'(hs_fall[1] - hs_fall[0]), 32'd3200);
        chk("vs_low_clks", 32'(vs_low), 32'd6400);
        chk("row_blank_clks", 32'(row_blank), 32'd12800);
        chk("fs_count", 32'(n_fs), 32'd3);
        chk("fs_wrap_first", 32'(fs_k[1]), 32'd25600);
        chk("fs_period", 32'(fs_k[2] - fs_k[1]), 32'(FRAME_CLK));
        chk("scan_col_5", 32'(col_5_2), 32'd5);
        chk("scan_row_2", 32'(row_5_2), 32'd2);
        chk("pix_5_2_rgb", 32'(rgb_5_2), 32'h52A);
        chk("pix_5_2_von", 32'(von_5_2), 32'd1);
        chk("blank_leak", 32'(blank_leak), 32'd0);
        chk("fff_clks", 32'(fff_clks), 32'd10240);

        // Mid-frame reset at row 3, col 300 while a visible pixel is showing.
        chk("pre_rst_col", 32'(col), 32'd300);
        chk("pre_rst_row", 32'(row), 32'd3);
        chk("pre_rst_von", 32'(video_on), 32'd1);
        rst = 1'b1;
        gpu_const = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state("mid");
        rst = 1'b0;

        run_span(6500, 32'h7fffffff);
        chk("re_col_trace", 32'(e_col), 32'd0);
        chk("re_row_trace", 32'(e_row), 32'd0);
        chk("re_hs_trace", 32'(e_hs), 32'd0);
        chk("re_rgb_trace", 32'(e_rgb), 32'd0);
        chk("re_fs_trace", 32'(e_fs), 32'd0);
        chk("re_col_first_tick", 32'(col_k4), 32'd1);
        chk("re_pix_5_2_rgb", 32'(rgb_5_2), 32'h52A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
